// File: rtl/led_mux_ctrl.sv
// ---------------------------------------------------------------------------
// led_mux_ctrl
//   Sequencer for the LED output multiplexer behind the ALU. ALU results
//   arrive over a valid/ready handshake. The controller latches the function
//   value and drives the mux select. When a result carries the overflow flag,
//   the controller shows a blinking overflow indication for HOLD_CYCLES
//   cycles. It then falls back to showing the latched function value.
//
// Ports
//   Clk          in   1      system clock, rising edge
//   Rst_n        in   1      asynchronous active-low reset
//   Clear        in   1      synchronous clear back to IDLE, latched value zeroed
//   ResultValid  in   1      ALU result valid
//   ResultReady  out  1      a result can be accepted this cycle
//   FuncIn       in   WIDTH  ALU function result
//   OverflowIn   in   1      ALU overflow flag belonging to FuncIn
//   Sel          out  1      LED mux select: 0=function value, 1=overflow
//   FuncOut      out  WIDTH  latched function value for the LED mux
//   OverflowOut  out  1      blinking overflow bit for the LED mux
//   Busy         out  1      high while the overflow indication is shown
// ---------------------------------------------------------------------------
module led_mux_ctrl #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int BLINK_HALF  = 6250000
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clear,
  input  logic             ResultValid,
  output logic             ResultReady,
  input  logic [WIDTH-1:0] FuncIn,
  input  logic             OverflowIn,
  output logic             Sel,
  output logic [WIDTH-1:0] FuncOut,
  output logic             OverflowOut,
  output logic             Busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_OVF  = 2'd2;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic          transfer;

  // Ready is decoded directly from the state, so it is valid in the same
  // cycle. It is forced low during Clear so that a result presented together
  // with Clear is never seen as accepted by the sender.
  assign ResultReady = (state != ST_OVF) && !Clear;
  assign transfer    = ResultValid && ResultReady;

  // The state, the counters and every output are registered here.
  // Clear takes priority over everything else.
  // The overflow dwell counts hold_cnt down from HOLD_CYCLES-1 to 0.
  // This keeps Sel high for exactly HOLD_CYCLES cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      Sel         <= 1'b0;
      FuncOut     <= '0;
      OverflowOut <= 1'b0;
      Busy        <= 1'b0;
    end else if (Clear) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      Sel         <= 1'b0;
      FuncOut     <= '0;
      OverflowOut <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SHOW: begin
          if (transfer) begin
            FuncOut <= FuncIn;
            if (OverflowIn) begin
              state       <= ST_OVF;
              hold_cnt    <= HOLD_LOAD;
              blink_cnt   <= BLINK_LOAD;
              Sel         <= 1'b1;
              Busy        <= 1'b1;
              OverflowOut <= 1'b1;
            end else begin
              state <= ST_SHOW;
            end
          end
        end
        ST_OVF: begin
          if (hold_cnt == '0) begin
            state       <= ST_SHOW;
            Sel         <= 1'b0;
            Busy        <= 1'b0;
            OverflowOut <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
            // The blink phase flips each time its half-period runs out.
            if (blink_cnt == '0) begin
              OverflowOut <= ~OverflowOut;
              blink_cnt   <= BLINK_LOAD;
            end else begin
              blink_cnt <= blink_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_mux_ctrl
//   Scoreboard bench for led_mux_ctrl. Two instances are used. Instance 0
//   uses HOLD_CYCLES=8 and BLINK_HALF=2. Instance 1 uses HOLD_CYCLES=1 and
//   BLINK_HALF=1.
//   The reference model describes an overflow episode by the number of
//   cycles elapsed since it began. The blink level is computed from that
//   elapsed count with integer division.
// ---------------------------------------------------------------------------
module tb_led_mux_ctrl;

  typedef struct packed {
    logic       sel;
    logic       busy;
    logic       ovfo;
    logic       ready;
    logic       chkReady;
    logic [3:0] func;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       clr [2];
  logic       vld [2];
  logic [3:0] fin [2];
  logic       ovi [2];
  logic       rdy [2];
  logic       sel [2];
  logic [3:0] fout[2];
  logic       ovo [2];
  logic       busy[2];

  // Next-cycle input values. These are set by the directed code or by the
  // random generator.
  logic       nClr[2];
  logic       nVld[2];
  logic [3:0] nFin[2];
  logic       nOvi[2];

  // Reference model state for each instance.
  bit         mOvf [2];
  int         mK   [2];
  logic [3:0] mFunc[2];
  bit         acc  [2];
  bit         randomMode = 1'b0;

  exp_t q0[$];
  exp_t q1[$];
  int   passes = 0;
  int   total  = 0;

  always #5 Clk = ~Clk;

  led_mux_ctrl #(.WIDTH(4), .HOLD_CYCLES(8), .BLINK_HALF(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Clear(clr[0]), .ResultValid(vld[0]),
    .ResultReady(rdy[0]), .FuncIn(fin[0]), .OverflowIn(ovi[0]),
    .Sel(sel[0]), .FuncOut(fout[0]), .OverflowOut(ovo[0]), .Busy(busy[0])
  );

  led_mux_ctrl #(.WIDTH(4), .HOLD_CYCLES(1), .BLINK_HALF(1)) dutEdge (
    .Clk(Clk), .Rst_n(Rst_n), .Clear(clr[1]), .ResultValid(vld[1]),
    .ResultReady(rdy[1]), .FuncIn(fin[1]), .OverflowIn(ovi[1]),
    .Sel(sel[1]), .FuncOut(fout[1]), .OverflowOut(ovo[1]), .Busy(busy[1])
  );

  function automatic int holdOf(int i);
    return (i == 0) ? 8 : 1;
  endfunction

  function automatic int blinkOf(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      mOvf[i]  = 1'b0;
      mK[i]    = 0;
      mFunc[i] = 4'h0;
      acc[i]   = 1'b0;
    end
  endtask

  // One rising edge of the reference model. Clear wins. While the overflow
  // indication is shown, elapsed time advances and inputs are ignored.
  // Otherwise a valid result is taken.
  task automatic modelEdge(int i);
    acc[i] = 1'b0;
    if (Rst_n) begin
      if (clr[i]) begin
        mOvf[i]  = 1'b0;
        mFunc[i] = 4'h0;
      end else if (mOvf[i]) begin
        mK[i]++;
        if (mK[i] >= holdOf(i)) mOvf[i] = 1'b0;
      end else if (vld[i]) begin
        acc[i]   = 1'b1;
        mFunc[i] = fin[i];
        if (ovi[i]) begin
          mOvf[i] = 1'b1;
          mK[i]   = 0;
        end
      end
    end
  endtask

  function automatic exp_t expected(int i);
    exp_t e;
    e.sel      = mOvf[i];
    e.busy     = mOvf[i];
    e.func     = mFunc[i];
    e.ovfo     = mOvf[i] ? (((mK[i] / blinkOf(i)) % 2) == 0) : 1'b0;
    e.ready    = !mOvf[i] && !clr[i];
    e.chkReady = Rst_n;
    return e;
  endfunction

  task automatic pushAll();
    q0.push_back(expected(0));
    q1.push_back(expected(1));
  endtask

  // A valid that has not been accepted is held unchanged. Clear is random
  // on every cycle.
  task automatic genNext(int i);
    nClr[i] = ($urandom_range(0, 19) == 0);
    if (!(vld[i] && !acc[i])) begin
      nVld[i] = ($urandom_range(0, 2) != 0);
      nFin[i] = 4'($urandom);
      nOvi[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic setIn(int i, bit c, bit v, logic [3:0] f, bit o);
    nClr[i] = c;
    nVld[i] = v;
    nFin[i] = f;
    nOvi[i] = o;
  endtask

  // Advance one clock for both instances. The model takes the edge first.
  // Then the next inputs are driven and the expected view of the new cycle
  // is queued.
  task automatic applyStimulus();
    @(posedge Clk);
    modelEdge(0);
    modelEdge(1);
    #1;
    if (randomMode) begin
      genNext(0);
      genNext(1);
    end
    for (int i = 0; i < 2; i++) begin
      clr[i] = nClr[i];
      vld[i] = nVld[i];
      fin[i] = nFin[i];
      ovi[i] = nOvi[i];
    end
    pushAll();
  endtask

  // Reset asserted in the middle of a clock period. Reset values must
  // appear before the next rising edge.
  task automatic resetPulse();
    @(posedge Clk);
    modelEdge(0);
    modelEdge(1);
    #3;
    Rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      setIn(i, 1'b0, 1'b0, 4'h0, 1'b0);
      clr[i] = 1'b0;
      vld[i] = 1'b0;
      fin[i] = 4'h0;
      ovi[i] = 1'b0;
    end
    resetModel();
    pushAll();
    @(negedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  task automatic cmp(int i, string name, int got, int want);
    total++;
    if (got == want) passes++;
    else $display("[TB] FAIL inst%0d %s got %0h expected %0h at %0t", i, name, got, want, $time);
  endtask

  task automatic checkOutput(int i, exp_t e);
    cmp(i, "Sel", int'(sel[i]), int'(e.sel));
    cmp(i, "Busy", int'(busy[i]), int'(e.busy));
    cmp(i, "FuncOut", int'(fout[i]), int'(e.func));
    cmp(i, "OverflowOut", int'(ovo[i]), int'(e.ovfo));
    if (e.chkReady) cmp(i, "ResultReady", int'(rdy[i]), int'(e.ready));
  endtask

  // The monitor pops one queued expectation per instance on each falling
  // edge. This keeps sampling away from the active edge.
  always @(negedge Clk) begin
    if (q0.size() > 0) checkOutput(0, q0.pop_front());
    if (q1.size() > 0) checkOutput(1, q1.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    Rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1'b0;
      vld[i] = 1'b0;
      fin[i] = 4'h0;
      ovi[i] = 1'b0;
      setIn(i, 1'b0, 1'b0, 4'h0, 1'b0);
    end
    resetModel();
    #1;
    pushAll();
    #11;
    Rst_n = 1'b1;
    $display("[TB] reset released");

    // Plain results followed by a replacement result.
    setIn(0, 1'b0, 1'b1, 4'hA, 1'b0); applyStimulus();
    setIn(0, 1'b0, 1'b1, 4'h3, 1'b0); applyStimulus();
    setIn(0, 1'b0, 1'b0, 4'h0, 1'b0); applyStimulus();

    // Overflow result, then a valid held through the whole dwell.
    setIn(0, 1'b0, 1'b1, 4'h7, 1'b1); applyStimulus();
    setIn(0, 1'b0, 1'b1, 4'h5, 1'b0);
    repeat (11) applyStimulus();
    setIn(0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) applyStimulus();

    // Clear during the third overflow cycle while a valid is offered.
    setIn(0, 1'b0, 1'b1, 4'h7, 1'b1); applyStimulus();
    setIn(0, 1'b0, 1'b1, 4'h9, 1'b0); applyStimulus();
    applyStimulus();
    applyStimulus();
    setIn(0, 1'b1, 1'b1, 4'h9, 1'b0); applyStimulus();
    setIn(0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) applyStimulus();

    // Single-cycle overflow on the edge-parameter instance.
    setIn(1, 1'b0, 1'b1, 4'hE, 1'b1); applyStimulus();
    setIn(1, 1'b0, 1'b1, 4'h2, 1'b0); applyStimulus();
    setIn(1, 1'b0, 1'b1, 4'hC, 1'b1); applyStimulus();
    setIn(1, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (3) applyStimulus();

    // Reset in the middle of an overflow episode.
    setIn(0, 1'b0, 1'b1, 4'hB, 1'b1); applyStimulus();
    setIn(0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (3) applyStimulus();
    resetPulse();
    repeat (2) applyStimulus();

    // Randomized traffic with one more mid-run reset.
    randomMode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) resetPulse();
      applyStimulus();
    end
    randomMode = 1'b0;
    setIn(0, 1'b0, 1'b0, 4'h0, 1'b0);
    setIn(1, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) applyStimulus();
    @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
